down_counter: RTL and testbench



---
 rtl/down_counter.sv | 97 +++++++++
 tb/tb_down_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable, pausable down-counter: runs from a programmed value to zero and
// pulses done at terminal count, with a one-clock delayed copy of done.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             done_delayed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           st, st_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             done_dly;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      cnt      <= '0;
      done_dly <= 1'b0;
    end else begin
      st       <= st_nxt;
      cnt      <= cnt_nxt;
      done_dly <= (st == DONE);
    end
  end

  // load outranks en in every state; a zero load skips RUN entirely
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
      st_nxt  = (load_val == '0) ? DONE : RUN;
    end else begin
      case (st)
        IDLE: ;
        RUN: begin
          if (en) begin
            cnt_nxt = cnt - ONE;
            if (cnt == ONE) st_nxt = DONE;
          end
        end
        DONE: begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end
        default: begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  assign q            = cnt;
  assign busy         = (st == RUN);
  assign done         = (st == DONE);
  assign done_delayed = done_dly;

  // embedded checkers; all quiet while reset is held
  a_pause: assert property (@(posedge clk) disable iff (!rstn)
    (!en && !load && st == RUN) |=> $stable(cnt));
  a_dec: assert property (@(posedge clk) disable iff (!rstn)
    (en && !load && st == RUN) |=> (cnt == $past(cnt) - ONE));
  a_dly: assert property (@(posedge clk) disable iff (!rstn)
    done |=> done_delayed);
  a_done_zero: assert property (@(posedge clk) disable iff (!rstn)
    done |-> (cnt == '0));
  a_busy_nz: assert property (@(posedge clk) disable iff (!rstn)
    busy |-> (cnt != '0));
  a_one_pulse: assert property (@(posedge clk) disable iff (!rstn)
    (done && !(load && load_val == '0)) |=> !done);

  c_pause: cover property (@(posedge clk) disable iff (!rstn)
    (!en && !load && st == RUN));
  c_dec: cover property (@(posedge clk) disable iff (!rstn)
    (en && !load && st == RUN));
  c_done: cover property (@(posedge clk) disable iff (!rstn) done);
  c_busy: cover property (@(posedge clk) disable iff (!rstn) busy);
  c_zero_reload: cover property (@(posedge clk) disable iff (!rstn)
    (done && load && load_val == '0));

endmodule

// File: tb/tb_down_counter.sv
// Randomized scoreboard bench for down_counter against a remaining-events model.
module tb_down_counter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en = 1'b0;
  logic [W-1:0] q;
  logic         busy, done, done_delayed;

  down_counter #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .en(en),
    .q(q), .busy(busy), .done(done), .done_delayed(done_delayed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit busy;
    bit done;
    bit dd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // model: events still owed in the current budget, plus the done history
  int rem = 0;
  bit running = 0;
  bit done_m = 0;
  bit dd_m = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit l, input int lv, input bit e);
    exp_t x;
    if (!rstn) begin
      rem = 0; running = 0; done_m = 0; dd_m = 0;
    end else begin
      dd_m = done_m;
      if (l) begin
        rem = lv;
        running = (lv != 0);
        done_m = (lv == 0);
      end else if (running && e) begin
        rem = rem - 1;
        running = (rem != 0);
        done_m = (rem == 0);
      end else begin
        done_m = 0;
      end
    end
    x.q = rem; x.busy = running; x.done = done_m; x.dd = dd_m;
    sb.push_back(x);
  endtask

  task automatic cyc(input bit l, input int lv, input bit e);
    @(negedge clk);
    load = l; load_val = W'(lv); en = e;
    model_step(l, lv, e);
  endtask

  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("q", int'(q), x.q);
      chk("busy", int'(busy), int'(x.busy));
      chk("done", int'(done), int'(x.done));
      chk("done_delayed", int'(done_delayed), int'(x.dd));
    end
  end

  initial begin
    int lv;
    #1;
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    // reset held for 3 cycles
    repeat (3) cyc(0, 0, 0);
    @(negedge clk); rstn = 1'b1;
    load = 0; en = 0; model_step(0, 0, 0);

    // load 5, run to done, then idle
    cyc(1, 5, 0);
    repeat (8) cyc(0, 0, 1);
    // load 3 with en pattern 1,0,0,1,1
    cyc(1, 3, 0);
    cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 1);
    repeat (3) cyc(0, 0, 0);
    // zero load, then zero reload during DONE
    cyc(1, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    // reload at q==1 with en high
    cyc(1, 2, 0); cyc(0, 0, 1); cyc(1, 9, 1);
    repeat (11) cyc(0, 0, 1);
    // all-ones budget
    cyc(1, 255, 0);
    repeat (258) cyc(0, 0, 1);

    // load 200, run to 100, then async reset mid-cycle
    cyc(1, 200, 0);
    repeat (100) cyc(0, 0, 1);
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("async_q", int'(q), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_dd", int'(done_delayed), 0);
    cyc(0, 0, 1);
    @(negedge clk); rstn = 1'b1;
    load = 0; en = 1; model_step(0, 0, 1);
    repeat (4) cyc(0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 5))
          0: lv = 0;
          1: lv = 1;
          2: lv = 255;
          default: lv = $urandom_range(1, 20);
        endcase
        cyc(1, lv, $urandom_range(0, 1) == 1);
      end else begin
        cyc(0, $urandom_range(0, 255), $urandom_range(0, 3) != 0);
      end
    end
    repeat (3) cyc(0, 0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
